// File: rtl/icache_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_ctrl_if
// Description : Fetch-port and memory-port bundle for the instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_ctrl_if;
    // datapath fetch side
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iflush;
    // memory side
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;

    modport slave (
        input  imemREN, imemaddr, iflush, iload, iwait,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iflush, iload, iwait,
        input  ihit, imemload, iREN, iaddr
    );
endinterface
`default_nettype wire

// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_ctrl
// Description : Direct-mapped 16-frame read-only instruction cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_ctrl (
    input  wire logic    CLK,
    input  wire logic    nRST,
    icache_ctrl_if.slave bus
);
    localparam int unsigned c_num_frames = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [15:0] r_valid;
    logic [25:0] r_tag  [c_num_frames];
    logic [31:0] r_data [c_num_frames];
    logic [31:0] r_miss_addr;

    logic [3:0]  w_idx;
    logic [25:0] w_tag;
    logic [3:0]  w_miss_idx;
    logic        w_hit;
    logic        w_miss;
    logic        w_fill;
    logic        w_ihit;
    logic [31:0] w_imemload;
    logic        w_iren;
    logic [31:0] w_iaddr;

    assign w_idx      = bus.imemaddr[5:2];
    assign w_tag      = bus.imemaddr[31:6];
    assign w_miss_idx = r_miss_addr[5:2];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    always_comb begin
        w_next_state = r_state;
        w_ihit       = 1'b0;
        w_imemload   = 32'h0;
        w_iren       = 1'b0;
        w_iaddr      = 32'h0;
        w_miss       = 1'b0;
        w_fill       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.imemREN) begin
                    if (w_hit) begin
                        w_ihit     = 1'b1;
                        w_imemload = r_data[w_idx];
                    end else begin
                        w_miss       = 1'b1;
                        w_next_state = FETCH;
                    end
                end
            end
            FETCH: begin
                // Memory port is driven purely from registered state so it stays
                // stable across the whole fetch regardless of the live PC.
                w_iren  = 1'b1;
                w_iaddr = r_miss_addr;
                if (!bus.iwait) begin
                    w_fill       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign bus.ihit     = w_ihit;
    assign bus.imemload = w_imemload;
    assign bus.iREN     = w_iren;
    assign bus.iaddr    = w_iaddr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_miss_addr <= 32'h0;
        end else if (w_miss) begin
            r_miss_addr <= {bus.imemaddr[31:2], 2'b00};
        end
    end

    // Flush is placed after the fill so a coincident flush leaves the frame invalid.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= 16'h0;
        end else begin
            if (w_fill) begin
                r_valid[w_miss_idx] <= 1'b1;
            end
            if (bus.iflush) begin
                r_valid <= 16'h0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < c_num_frames; i++) begin
                r_tag[i]  <= 26'h0;
                r_data[i] <= 32'h0;
            end
        end else if (w_fill) begin
            r_tag[w_miss_idx]  <= r_miss_addr[31:6];
            r_data[w_miss_idx] <= bus.iload;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_ctrl
// Description : Randomized scoreboard bench for icache_ctrl with a line-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_icache_ctrl;
    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    icache_ctrl_if ifc();

    icache_ctrl u_dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (ifc.slave)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb_q[$];
    logic [31:0] mem_ov [logic [31:0]];
    logic [31:0] line_of [16];
    bit          present [16];
    logic [31:0] exp_miss_addr = 32'h0;
    int          next_wait     = 0;
    bit          flush_on_fill = 1'b0;
    bit          drv_flush     = 1'b0;
    bit          mem_flush     = 1'b0;
    int          cnt           = 0;
    bit          in_fetch      = 1'b0;
    logic [25:0] tags [4] = '{26'h0, 26'h1, 26'h3FF_FFFF, 26'h123_4567};

    assign ifc.iflush = drv_flush | mem_flush;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Backing memory: per-word hash unless a specific word is pinned.
    function automatic logic [31:0] mem_of(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (mem_ov.exists(w)) return mem_ov[w];
        return (w * 32'h9E37_79B1) ^ 32'hC3A5_1F0F;
    endfunction

    // Cache model: each of 16 slots holds the word number (addr/4) it caches.
    function automatic bit model_hit(input logic [31:0] a);
        logic [31:0] line;
        int          slot;
        line = a >> 2;
        slot = int'(line % 16);
        return present[slot] && (line_of[slot] == line);
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        logic [31:0] line;
        int          slot;
        line = a >> 2;
        slot = int'(line % 16);
        present[slot] = 1'b1;
        line_of[slot] = line;
    endfunction

    function automatic void model_flush();
        foreach (present[i]) present[i] = 1'b0;
    endfunction

    // Memory responder: next_wait busy cycles, then data for one cycle.
    initial begin
        ifc.iwait = 1'b1;
        ifc.iload = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_flush = 1'b0;
            if (ifc.iREN) begin
                if (!in_fetch) begin
                    in_fetch = 1'b1;
                    cnt      = next_wait;
                end
                if (cnt > 0) begin
                    ifc.iwait = 1'b1;
                    ifc.iload = $urandom;
                    cnt--;
                end else begin
                    ifc.iwait = 1'b0;
                    ifc.iload = mem_of(ifc.iaddr);
                    if (flush_on_fill) mem_flush = 1'b1;
                end
            end else begin
                in_fetch  = 1'b0;
                ifc.iwait = 1'b1;
                ifc.iload = $urandom;
            end
        end
    end

    // Monitor: every ihit consumes one scoreboard entry.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (ifc.iREN) check("iaddr_in_fetch", ifc.iaddr, exp_miss_addr);
            if (ifc.ihit) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ihit: ihit=1 with no pending request, addr %h", ifc.imemaddr);
                end else begin
                    e = sb_q.pop_front();
                    check("imemload", ifc.imemload, e.data);
                end
            end else begin
                check("imemload_zero", ifc.imemload, 32'h0);
            end
        end
    end

    task automatic do_fetch(input logic [31:0] a, input int w);
        bit   pred;
        bit   seen;
        int   n;
        exp_t e;
        pred      = model_hit(a);
        next_wait = w;
        if (!pred) exp_miss_addr = {a[31:2], 2'b00};
        e.addr = a;
        e.data = mem_of(a);
        sb_q.push_back(e);
        ifc.imemREN  = 1'b1;
        ifc.imemaddr = a;
        seen = 1'b0;
        for (n = 0; n < 64; n++) begin
            @(negedge clk);
            if (n == 0) check_bit("hit_predict", ifc.ihit, pred);
            if (n == 1 && !pred) check_bit("iREN_after_miss", ifc.iREN, 1'b1);
            if (ifc.ihit) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL fetch_timeout: no ihit for addr %h within 64 cycles", a);
            sb_q.delete();
        end else begin
            check("hit_latency", n, pred ? 0 : w + 2);
        end
        if (!pred) model_fill(a);
        @(posedge clk);
        #1;
        ifc.imemREN = 1'b0;
        if (pred) check_bit("no_iREN_on_hit", ifc.iREN, 1'b0);
    endtask

    // Start a miss, then redirect/drop the request while the fetch is in flight.
    task automatic fetch_release(input logic [31:0] a, input int w,
                                 input logic [31:0] redir, input bit fl);
        bit done;
        done          = 1'b0;
        next_wait     = w;
        flush_on_fill = fl;
        exp_miss_addr = {a[31:2], 2'b00};
        ifc.imemREN   = 1'b1;
        ifc.imemaddr  = a;
        @(negedge clk);
        check_bit("release_first_miss", ifc.ihit, 1'b0);
        @(posedge clk);
        #1;
        check_bit("release_iREN", ifc.iREN, 1'b1);
        ifc.imemaddr = redir;
        ifc.imemREN  = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (!ifc.iREN) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        flush_on_fill = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL release_timeout: fetch of %h never completed", a);
        end
        if (fl) model_flush();
        else    model_fill(a);
    endtask

    task automatic flush_pulse();
        drv_flush = 1'b1;
        @(posedge clk);
        #1;
        drv_flush = 1'b0;
        model_flush();
    endtask

    initial begin
        logic [31:0] a;
        int          t;
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          t;
        nrst         = 1'b0;
        ifc.imemREN  = 1'b1;
        ifc.imemaddr = 32'h0000_0040;
        model_flush();
        mem_ov[32'h0000_0104] = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("reset_ihit", ifc.ihit, 1'b0);
        check("reset_imemload", ifc.imemload, 32'h0);
        check_bit("reset_iREN", ifc.iREN, 1'b0);
        check("reset_iaddr", ifc.iaddr, 32'h0);
        ifc.imemREN = 1'b0;
        nrst        = 1'b1;
        @(posedge clk);
        #1;

        // cold misses, hits, byte offset ignored
        do_fetch(32'h0000_0040, 2);
        do_fetch(32'h0000_0104, 3);
        do_fetch(32'h0000_0104, 0);
        do_fetch(32'h0000_0106, 0);
        do_fetch(32'h0000_0040, 0);

        // conflict eviction in slot 1
        do_fetch(32'h0000_0144, 1);
        do_fetch(32'h0000_0104, 2);

        // redirect mid-fetch: fill keeps the latched address
        fetch_release(32'h0000_0200, 3, 32'h0000_0300, 1'b0);
        do_fetch(32'h0000_0200, 0);
        do_fetch(32'h0000_0300, 1);

        // flush after four fills
        do_fetch(32'h0000_0400, 0);
        do_fetch(32'h0000_0404, 1);
        do_fetch(32'h0000_0408, 2);
        do_fetch(32'h0000_040C, 3);
        flush_pulse();
        do_fetch(32'h0000_0400, 0);
        do_fetch(32'h0000_0404, 1);
        do_fetch(32'h0000_0408, 0);
        do_fetch(32'h0000_040C, 2);

        // flush coincident with the fill edge
        fetch_release(32'h0000_0510, 2, 32'h0000_0510, 1'b1);
        do_fetch(32'h0000_0510, 1);
        do_fetch(32'h0000_0510, 0);

        // asynchronous reset during a fetch
        do_fetch(32'h0000_0700, 1);
        next_wait     = 6;
        exp_miss_addr = 32'h0000_0804;
        ifc.imemREN   = 1'b1;
        ifc.imemaddr  = 32'h0000_0804;
        @(posedge clk);
        #1;
        check_bit("fetch_before_reset", ifc.iREN, 1'b1);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        check_bit("iREN_async_reset", ifc.iREN, 1'b0);
        check("iaddr_async_reset", ifc.iaddr, 32'h0);
        ifc.imemREN = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        model_flush();
        do_fetch(32'h0000_0700, 2);

        // randomized traffic over a small tag/slot space
        for (int k = 0; k < 200; k++) begin
            t = int'($urandom_range(0, 3));
            a = {tags[t], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 15) == 0) flush_pulse();
            do_fetch(a, int'($urandom_range(0, 4)));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
